// File: rtl/imuldiv_int_mul_iterative_param_pkg.sv
// Shared encodings for the parametrised iterative shift-add multiplier.
package imuldiv_int_mul_iterative_param_pkg;

  localparam logic [1:0] MODE_UU = 2'b00;
  localparam logic [1:0] MODE_SS = 2'b01;
  localparam logic [1:0] MODE_SU = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Width of the CALC step counter; must hold W-1.
  function automatic int count_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/imuldiv_int_mul_iterative_param_dpath.sv
// Datapath: operand magnitudes and signs, shift registers, accumulator and
// final sign application for the iterative multiplier.
module imuldiv_int_mul_iterative_param_dpath
  import imuldiv_int_mul_iterative_param_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     mode,
  output logic [2*W-1:0] result,
  output logic           b_next_zero
);

  logic [2*W-1:0] a_reg;
  logic [W-1:0]   b_reg;
  logic [2*W-1:0] acc;
  logic           neg;

  logic           sign_a_in;
  logic           sign_b_in;
  logic [W-1:0]   mag_a_in;
  logic [W-1:0]   mag_b_in;

  // Negating a zero magnitude yields zero, so a zero product never picks up a sign.
  function automatic logic [2*W-1:0] apply_sign(input logic [2*W-1:0] mag,
                                                input logic neg_in);
    return neg_in ? -mag : mag;
  endfunction

  // Mode 11 falls through as unsigned; the most-negative value negates to 2^(W-1).
  always_comb begin
    sign_a_in = ((mode == MODE_SS) || (mode == MODE_SU)) && a[W-1];
    sign_b_in = (mode == MODE_SS) && b[W-1];
    mag_a_in  = sign_a_in ? -a : a;
    mag_b_in  = sign_b_in ? -b : b;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      neg   <= 1'b0;
    end else if (load) begin
      a_reg <= {{W{1'b0}}, mag_a_in};
      b_reg <= mag_b_in;
      acc   <= '0;
      neg   <= sign_a_in ^ sign_b_in;
    end else if (step) begin
      if (b_reg[0]) acc <= acc + a_reg;
      a_reg <= a_reg << 1;
      b_reg <= b_reg >> 1;
    end
  end

  assign b_next_zero = (b_reg[W-1:1] == '0);
  assign result      = apply_sign(acc, neg);

endmodule

// File: rtl/imuldiv_int_mul_iterative_param.sv
// Iterative shift-add multiplier top: val/rdy handshake, FSM and step counter.
module imuldiv_int_mul_iterative_param
  import imuldiv_int_mul_iterative_param_pkg::*;
#(
  parameter int W          = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   mulreq_msg_a,
  input  logic [W-1:0]   mulreq_msg_b,
  input  logic [1:0]     mulreq_msg_mode,
  input  logic           mulreq_val,
  output logic           mulreq_rdy,
  output logic [2*W-1:0] mulresp_msg_result,
  output logic           mulresp_val,
  input  logic           mulresp_rdy
);

  localparam int CNT_W = count_w(W);

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             load;
  logic             step;
  logic             b_next_zero;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Handshake outputs are gated by reset so nothing is offered while it is held low.
  always_comb begin
    state_next  = state;
    count_next  = count;
    mulreq_rdy  = 1'b0;
    mulresp_val = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    case (state)
      ST_IDLE: begin
        mulreq_rdy = reset;
        if (mulreq_val && reset) begin
          load       = 1'b1;
          count_next = '0;
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        step       = 1'b1;
        count_next = count + CNT_W'(1);
        if ((count == CNT_W'(W - 1)) || ((EARLY_EXIT != 0) && b_next_zero))
          state_next = ST_DONE;
      end
      ST_DONE: begin
        mulresp_val = reset;
        if (mulresp_rdy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  imuldiv_int_mul_iterative_param_dpath #(
    .W (W)
  ) u_dpath (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .step        (step),
    .a           (mulreq_msg_a),
    .b           (mulreq_msg_b),
    .mode        (mulreq_msg_mode),
    .result      (mulresp_msg_result),
    .b_next_zero (b_next_zero)
  );

endmodule

// File: tb/tb_imuldiv_int_mul_iterative_param.sv
// Directed bench: two W=32 instances (EARLY_EXIT 0 and 1) share one request
// stream; a W=8 instance covers a small directed table plus a random sweep.
module tb_imuldiv_int_mul_iterative_param;

  logic        clk = 1'b0;
  logic        reset;

  logic [31:0] req_a, req_b;
  logic [1:0]  req_mode;
  logic        req_val;
  logic        resp_rdy;
  logic        rdy0, rdy1, rv0, rv1;
  logic [63:0] res0, res1;

  logic [7:0]  a8, b8;
  logic [1:0]  mode8;
  logic        val8, rdy8, rv8, rrdy8;
  logic [15:0] res8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imuldiv_int_mul_iterative_param #(.W(32), .EARLY_EXIT(0)) u_full (
    .clk(clk), .reset(reset),
    .mulreq_msg_a(req_a), .mulreq_msg_b(req_b), .mulreq_msg_mode(req_mode),
    .mulreq_val(req_val), .mulreq_rdy(rdy0),
    .mulresp_msg_result(res0), .mulresp_val(rv0), .mulresp_rdy(resp_rdy)
  );

  imuldiv_int_mul_iterative_param #(.W(32), .EARLY_EXIT(1)) u_early (
    .clk(clk), .reset(reset),
    .mulreq_msg_a(req_a), .mulreq_msg_b(req_b), .mulreq_msg_mode(req_mode),
    .mulreq_val(req_val), .mulreq_rdy(rdy1),
    .mulresp_msg_result(res1), .mulresp_val(rv1), .mulresp_rdy(resp_rdy)
  );

  imuldiv_int_mul_iterative_param #(.W(8), .EARLY_EXIT(1)) u_w8 (
    .clk(clk), .reset(reset),
    .mulreq_msg_a(a8), .mulreq_msg_b(b8), .mulreq_msg_mode(mode8),
    .mulreq_val(val8), .mulreq_rdy(rdy8),
    .mulresp_msg_result(res8), .mulresp_val(rv8), .mulresp_rdy(rrdy8)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Latency is the edge (counted from the accept edge) at which mulresp_val is
  // first sampled high, so the earliest response fire is at E+N+1.
  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] mode, input logic [63:0] exp, input int n_early);
    bit s0 = 0, s1 = 0;
    int lat0 = 0, lat1 = 0;
    logic [63:0] r0 = '0, r1 = '0;
    req_a = a; req_b = b; req_mode = mode; req_val = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      req_val = 1'b0;
      if (!s0 && rv0) begin s0 = 1; lat0 = j + 1; r0 = res0; end
      if (!s1 && rv1) begin s1 = 1; lat1 = j + 1; r1 = res1; end
      if (s0 && s1) break;
    end
    chk({tag, "_res_full"}, r0, exp);
    chk({tag, "_res_early"}, r1, exp);
    chk({tag, "_lat_full"}, 64'(lat0), 64'd33);
    chk({tag, "_lat_early"}, 64'(lat1), 64'(n_early + 1));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] mode, input logic [15:0] exp);
    bit seen = 0;
    logic [15:0] r = '0;
    a8 = a; b8 = b; mode8 = mode; val8 = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      val8 = 1'b0;
      if (rv8) begin seen = 1; r = res8; break; end
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk(tag, 64'(r), 64'(exp));
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] mode);
    longint ea, eb;
    ea = (mode == 2'b01 || mode == 2'b10) ? longint'($signed(a)) : longint'(a);
    eb = (mode == 2'b01) ? longint'($signed(b)) : longint'(b);
    return 16'(ea * eb);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_resp;
    reset = 1'b0; req_a = '0; req_b = '0; req_mode = '0; req_val = 1'b0; resp_rdy = 1'b1;
    a8 = '0; b8 = '0; mode8 = '0; val8 = 1'b0; rrdy8 = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_rdy_low", 64'(rdy0), 64'd0);
    chk("rst_val_low", 64'(rv0), 64'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_rdy", 64'(rdy0), 64'd1);
    chk("post_rst_val", 64'(rv0), 64'd0);
    chk("post_rst_res", res0, 64'd0);
    @(negedge clk);

    run32("uu_max",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 64'hFFFF_FFFE_0000_0001, 32);
    run32("ss_m3x7",   32'hFFFF_FFFD, 32'h0000_0007, 2'b01, 64'hFFFF_FFFF_FFFF_FFEB, 3);
    run32("ss_minmin", 32'h8000_0000, 32'h8000_0000, 2'b01, 64'h4000_0000_0000_0000, 32);
    run32("ss_0xmin",  32'h0000_0000, 32'h8000_0000, 2'b01, 64'h0, 32);
    run32("ss_minx0",  32'h8000_0000, 32'h0000_0000, 2'b01, 64'h0, 1);
    run32("su_m2",     32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'b10, 64'hFFFF_FFFE_0000_0002, 32);
    run32("m11_uu",    32'hFFFF_FFFF, 32'h0000_0002, 2'b11, 64'h0000_0001_FFFF_FFFE, 2);

    // Backpressure with a request held valid the whole time.
    resp_rdy = 1'b0;
    req_a = 32'd7; req_b = 32'd9; req_mode = 2'b00; req_val = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (rv0 && rv1) break;
    end
    chk("bp_both_done", 64'(rv0 && rv1), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_res_full", res0, 64'd63);
      chk("bp_res_early", res1, 64'd63);
      chk("bp_reqrdy", 64'({rdy0, rdy1}), 64'd0);
      chk("bp_val", 64'({rv0, rv1}), 64'd3);
    end
    req_val = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    chk("bp_idle_rdy", 64'({rdy0, rdy1}), 64'd3);
    chk("bp_idle_val", 64'({rv0, rv1}), 64'd0);

    // Reset pulse in the middle of CALC abandons the operation.
    req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF; req_mode = 2'b00; req_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_val", 64'({rv0, rv1}), 64'd0);
    chk("mid_rst_rdy", 64'({rdy0, rdy1}), 64'd3);
    chk("mid_rst_res", res0, 64'd0);
    saw_resp = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (rv0 || rv1) saw_resp = 1;
    end
    chk("mid_rst_no_resp", 64'(saw_resp), 64'd0);
    run32("uu_5x0", 32'd5, 32'd0, 2'b00, 64'h0, 1);

    run8("w8_uu",    8'h0F, 8'h11, 2'b00, 16'h00FF);
    run8("w8_ss_min", 8'h80, 8'h80, 2'b01, 16'h4000);
    run8("w8_su",    8'hFF, 8'hFF, 2'b10, 16'hFF01);
    run8("w8_m11",   8'hFF, 8'hFF, 2'b11, 16'hFE01);
    run8("w8_ss_neg", 8'hFD, 8'h07, 2'b01, 16'hFFEB);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic [1:0] rm;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rm = 2'($urandom_range(0, 3));
      run8("w8_rand", ra, rb, rm, ref8(ra, rb, rm));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
